preg_free_serializer: RTL and testbench
=======================================

// Module: preg_free_serializer
// PURPOSE
// - Collects physical-register frees from N_LANES ROB commit lanes (up to N_LANES per cycle).
// - Buffers them and returns them to the Rename free list one per cycle, through its single
//   rob_commit_free_valid_i/rob_commit_free_preg_i port.
// - Sits between ROB commit and Rename. Drops p0 frees.
// - Holds off returns during misprediction recovery so Rename's free-list restore never races a free.
// PARAMETERS
// - N_PHYS      64  physical register count; PW = $clog2(N_PHYS)
// - N_LANES     2   ROB commit lanes, 1..4
// - FIFO_DEPTH  8   buffer entries, power of 2, >= 2*N_LANES
// PORTS
// - clk             in   1             clock
// - rst             in   1             synchronous, active-high reset
// - commit_valid_i  in   N_LANES       per-lane free request; lane 0 is the oldest instruction
// - commit_preg_i   in   N_LANES*PW    lane k preg at bits [k*PW +: PW]
// - commit_ready_o  out  1             all lanes accepted this cycle when 1
// - recover_i       in   1             same signal as the Rename recover_i
// - free_valid_o    out  1             to Rename rob_commit_free_valid_i
// - free_preg_o     out  PW            to Rename rob_commit_free_preg_i
// - occupancy_o     out  $clog2(FIFO_DEPTH)+1   entries buffered
// - dup_err_o       out  1             sticky duplicate-free flag (macro only; else tied 0)
// BEHAVIOUR
// - Reset: FIFO empty, head=tail=0.
//   - occupancy_o=0, free_valid_o=0, free_preg_o=0, commit_ready_o=1, dup_err_o=0.
//   - Reset mid-operation discards all buffered frees.
// - Ready rule: commit_ready_o = (occupancy <= FIFO_DEPTH-N_LANES).
//   - Combinational from registered occupancy only; never depends on commit_valid_i or recover_i.
// - Enqueue when commit_ready_o is 1. Per cycle:
//   - Take the lanes with commit_valid_i=1 and commit_preg_i!=0.
//   - Write them compacted, in ascending lane order, at tail..tail+m-1 (mod FIFO_DEPTH).
//   - Lanes with preg 0 are consumed and not stored.
//   - When commit_ready_o is 0 nothing is written; the ROB must hold its lanes.
// - Dequeue: free_valid_o = (occupancy != 0) && !recover_i; free_preg_o = fifo[head].
//   - A free is consumed every cycle free_valid_o is 1. Rename has no backpressure on this port.
//   - While recover_i=1, free_valid_o=0 and the head is held. Buffered frees are never flushed:
//     committed instructions are older than any mispredicted branch.
// - Latency: a free enqueued in cycle t appears on free_valid_o in cycle t+1 at the earliest. No bypass.
// - Order: output order equals enqueue order. Within a cycle, lower lane comes out first.
// - Simultaneous enqueue and dequeue: occupancy_next = occupancy + m - (free_valid_o ? 1 : 0).
//   - Pointers wrap mod FIFO_DEPTH.
//   - Full and empty are decided by occupancy, never by pointer equality.
// - Overflow cannot occur given the ready rule. An assertion fires if occupancy would exceed FIFO_DEPTH.
// CONFIGURATION
// - Macro PREG_FREE_DUP_CHECK_EN.
// - Defined:
//   - An N_PHYS-bit in_flight vector is set on enqueue and cleared on dequeue.
//   - Enqueuing a preg whose bit is already set, or the same preg on two lanes in one cycle,
//     sets dup_err_o until rst. The entry is still enqueued.
// - Undefined: no vector is built; dup_err_o is tied 0.
// TESTING
// - Reset, then lane0=5, lane1=9 valid:
//   - free_preg_o=5 in t+1, 9 in t+2; occupancy_o=2 at t+1, 0 at t+3.
// - lane0=0, lane1=7: only 7 is emitted; p0 is never seen at free_valid_o.
// - Both lanes valid every cycle, FIFO_DEPTH=8:
//   - Occupancy climbs by 1 per cycle; commit_ready_o drops at occupancy 7.
//   - No loss: the output sequence equals the input sequence.
// - 3 frees buffered, recover_i=1 for 2 cycles:
//   - free_valid_o=0 for both cycles, occupancy held (plus any new enqueues).
//   - Drains in original order afterwards.
// - Wrap: 20 single-lane frees (pregs 32..51) interleaved with idle cycles.
//   - Output is exactly 32..51 across pointer wrap.
// - With PREG_FREE_DUP_CHECK_EN: enqueue 12 twice before it drains -> dup_err_o=1, stays set until rst.

Source files
------------

// File: rtl/preg_free_serializer.sv
// Collects up to N_LANES physical-register frees per cycle from ROB commit and returns them
// to Rename one per cycle, in order. Optional duplicate-free checking under PREG_FREE_DUP_CHECK_EN.
module preg_free_serializer #(
    parameter int N_PHYS     = 64,
    parameter int N_LANES    = 2,
    parameter int FIFO_DEPTH = 8,
    localparam int PW        = $clog2(N_PHYS),
    localparam int OW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_LANES-1:0]    commit_valid_i,
    input  logic [N_LANES*PW-1:0] commit_preg_i,
    output logic                  commit_ready_o,
    input  logic                  recover_i,
    output logic                  free_valid_o,
    output logic [PW-1:0]         free_preg_o,
    output logic [OW-1:0]         occupancy_o,
    output logic                  dup_err_o
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [PW-1:0]      fifo_q [FIFO_DEPTH];
    logic [AW-1:0]      head_q, tail_q;
    logic [OW-1:0]      occ_q, occ_d;
    logic [N_LANES-1:0] take;
    logic [AW-1:0]      woff [N_LANES];
    logic [PW-1:0]      lane_preg [N_LANES];
    logic [OW-1:0]      m;
    logic               deq;

    // Compaction: each accepted lane writes at tail + (number of accepted lanes below it).
    always_comb begin
        take = '0;
        m    = '0;
        for (int unsigned k = 0; k < N_LANES; k++) begin
            lane_preg[k] = commit_preg_i[k*PW +: PW];
            woff[k]      = AW'(m);
            take[k]      = commit_ready_o && commit_valid_i[k] && (lane_preg[k] != '0);
            m            = m + OW'(take[k]);
        end
    end

    assign commit_ready_o = (occ_q <= OW'(FIFO_DEPTH - N_LANES));
    assign deq            = (occ_q != '0) && !recover_i;
    assign free_valid_o   = deq;
    assign free_preg_o    = (occ_q != '0) ? fifo_q[head_q] : '0;
    assign occupancy_o    = occ_q;
    assign occ_d          = occ_q + m - OW'(deq);

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            assert (int'(occ_q) + int'(m) - int'(deq) <= FIFO_DEPTH);
            for (int unsigned k = 0; k < N_LANES; k++) begin
                if (take[k]) fifo_q[tail_q + woff[k]] <= lane_preg[k];
            end
            tail_q <= tail_q + AW'(m);
            if (deq) head_q <= head_q + AW'(1);
            occ_q <= occ_d;
        end
    end

`ifdef PREG_FREE_DUP_CHECK_EN
    logic [N_PHYS-1:0] inflight_q, inflight_d;
    logic              dup_q, dup_hit;

    // The departing head is cleared before new lanes are checked; lanes are set in order
    // so the same preg on two lanes in one cycle is caught by the second lane.
    always_comb begin
        inflight_d = inflight_q;
        dup_hit    = 1'b0;
        if (deq) inflight_d[free_preg_o] = 1'b0;
        for (int unsigned k = 0; k < N_LANES; k++) begin
            if (take[k]) begin
                if (inflight_d[lane_preg[k]]) dup_hit = 1'b1;
                inflight_d[lane_preg[k]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= '0;
            dup_q      <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            dup_q      <= dup_q | dup_hit;
        end
    end

    assign dup_err_o = dup_q;
`else
    assign dup_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_preg_free_serializer.sv
// Scoreboard bench for preg_free_serializer: accepted frees are queued as driven and
// compared against free_preg_o as they emerge; occupancy/ready/valid follow a count model.
module tb_preg_free_serializer;

    localparam int N_PHYS     = 64;
    localparam int N_LANES    = 2;
    localparam int FIFO_DEPTH = 8;
    localparam int PW         = 6;
    localparam int OW         = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [N_LANES-1:0]    cvalid = '0;
    logic [N_LANES*PW-1:0] cpreg = '0;
    logic                  recover = 1'b0;
    logic                  commit_ready_o;
    logic                  free_valid_o;
    logic [PW-1:0]         free_preg_o;
    logic [OW-1:0]         occupancy_o;
    logic                  dup_err_o;

    int   exp_q[$];
    int   pend_n    = 0;
    logic dup_pend  = 1'b0;
    logic exp_dup   = 1'b0;
    logic rst_d     = 1'b0;
    int   errs      = 0;
    int   checks    = 0;

    preg_free_serializer #(
        .N_PHYS(N_PHYS),
        .N_LANES(N_LANES),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .commit_valid_i(cvalid),
        .commit_preg_i(cpreg),
        .commit_ready_o(commit_ready_o),
        .recover_i(recover),
        .free_valid_o(free_valid_o),
        .free_preg_o(free_preg_o),
        .occupancy_o(occupancy_o),
        .dup_err_o(dup_err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Entries pushed since the last edge are not yet inside the DUT.
    always @(posedge clk) begin
        rst_d   <= rst;
        exp_dup <= rst ? 1'b0 : (exp_dup | dup_pend);
        dup_pend = 1'b0;
        pend_n   = 0;
    end

    always @(negedge clk) begin
        int exp_occ;
        int e;
        if (rst_d) begin
            check("rst_occ",   occupancy_o,    0);
            check("rst_valid", free_valid_o,   0);
            check("rst_preg",  free_preg_o,    0);
            check("rst_ready", commit_ready_o, 1);
            check("rst_dup",   dup_err_o,      0);
        end else if (!rst) begin
            exp_occ = exp_q.size() - pend_n;
            check("occ",   occupancy_o,    exp_occ);
            check("ready", commit_ready_o, (exp_occ <= FIFO_DEPTH - N_LANES) ? 1 : 0);
            check("valid", free_valid_o,   (exp_occ != 0 && !recover) ? 1 : 0);
            check("dup",   dup_err_o,      exp_dup);
            if (free_valid_o === 1'b1 && exp_occ > 0) begin
                e = exp_q.pop_front();
                check("preg", free_preg_o, e);
            end
        end
    end

    task automatic cyc(input logic [1:0] v, input int a, input int b, input logic rec,
                       output logic acc);
        @(posedge clk);
        #1;
        recover = rec;
        cvalid  = v;
        cpreg   = {6'(b), 6'(a)};
        acc     = commit_ready_o && !rst;
        if (acc) begin
            if (v[0] && a != 0) begin exp_q.push_back(a); pend_n++; end
            if (v[1] && b != 0) begin exp_q.push_back(b); pend_n++; end
        end
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) cyc(2'b00, 0, 0, 1'b0, acc);
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) cyc(2'b00, 0, 0, 1'b0, acc);
        idle(1);
        check("drained", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst     = 1'b1;
        cvalid  = '0;
        recover = 1'b0;
        exp_q.delete();
        pend_n  = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic acc;
        logic saw_stall;
        int   nv;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Two lanes in one cycle, lower lane first.
        cyc(2'b11, 5, 9, 1'b0, acc);
        idle(4);

        // p0 on lane 0 is consumed silently.
        cyc(2'b11, 0, 7, 1'b0, acc);
        idle(3);

        // Saturating stream: ready must drop and nothing may be lost.
        nv = 20;
        saw_stall = 1'b0;
        for (int i = 0; i < 14; i++) begin
            cyc(2'b11, nv, nv + 1, 1'b0, acc);
            if (acc) nv += 2;
            else saw_stall = 1'b1;
        end
        check("stream_stall", saw_stall, 1);
        drain();

        // Reset with frees buffered discards them.
        cyc(2'b11, 40, 41, 1'b0, acc);
        cyc(2'b11, 42, 43, 1'b0, acc);
        do_reset();
        idle(2);

        // Recovery holds the head without flushing.
        cyc(2'b11, 3, 4, 1'b1, acc);
        cyc(2'b01, 6, 0, 1'b1, acc);
        cyc(2'b00, 0, 0, 1'b1, acc);
        cyc(2'b00, 0, 0, 1'b1, acc);
        drain();

        // Pointer wrap with idle gaps.
        for (int i = 0; i < 20; i++) begin
            cyc(2'b01, 32 + i, 0, 1'b0, acc);
            idle(i % 3);
        end
        drain();

`ifdef PREG_FREE_DUP_CHECK_EN
        do_reset();
        cyc(2'b01, 12, 0, 1'b1, acc);
        cyc(2'b01, 12, 0, 1'b1, acc);
        dup_pend = 1'b1;
        drain();
        idle(3);
        do_reset();
        idle(1);
        cyc(2'b11, 12, 12, 1'b0, acc);
        dup_pend = 1'b1;
        drain();
        do_reset();
        idle(1);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
